// File: rtl/hmi_kport_dev_pkg.sv
// Shared types for the K-Port device emulator: joypad state, frame image and
// the joypad-to-frame mapping used by every channel.
package hmi_kport_dev_pkg;

  localparam logic [3:0] KP_ID_JOYPAD  = 4'b1111;
  localparam int         KP_FRAME_MAX  = 64;

  typedef struct packed {
    logic [6:1] b;
    logic       select;
    logic       run;
    logic       up;
    logic       right;
    logic       down;
    logic       left;
    logic       mode1;
    logic       mode2;
  } joypad_t;

  typedef logic [KP_FRAME_MAX-1:0] kp_frame_t;

  // Active-high frame image; bits at and above 'bits' are always zero so the
  // shifter drains to all-zero after exactly 'bits' shifts.
  function automatic kp_frame_t joypad_to_kp(joypad_t jp, logic en,
                                             logic [1:0] turbo_kill, int bits);
    kp_frame_t f;
    f       = '0;
    f[5:0]  = jp.b;
    f[0]    = jp.b[1] & ~turbo_kill[0];
    f[1]    = jp.b[2] & ~turbo_kill[1];
    f[6]    = jp.select;
    f[7]    = jp.run;
    f[8]    = jp.up;
    f[9]    = jp.right;
    f[10]   = jp.down;
    f[11]   = jp.left;
    f[12]   = jp.mode1;
    f[14]   = jp.mode2;
    f       = f | (kp_frame_t'(KP_ID_JOYPAD) << (bits - 4));
    if (!en) begin
      f = '0;
    end
    return f;
  endfunction

endpackage

// File: rtl/hmi_kport_dev_if.sv
// Console-side K-Port pin bundle; the console drives latch/clock/write pins,
// the device drives the serial read data.
interface hmi_kport_dev_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0] KP_LATCH;
  logic [NPORTS-1:0] KP_CLK;
  logic [NPORTS-1:0] KP_RW;
  logic [NPORTS-1:0] KP_DOUT;
  logic [NPORTS-1:0] KP_DIN;

  modport master (
    output KP_LATCH,
    output KP_CLK,
    output KP_RW,
    output KP_DOUT,
    input  KP_DIN
  );

  modport slave (
    input  KP_LATCH,
    input  KP_CLK,
    input  KP_RW,
    input  KP_DOUT,
    output KP_DIN
  );
endinterface

// File: rtl/hmi_kport_dev_chan.sv
// One K-Port channel: pin synchronisers, edge detection, frame shifter,
// turbo phase and host-write deserialiser.
module hmi_kport_chan
  import hmi_kport_dev_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_RATE  = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  joypad_t    jp,
  input  logic       en,
  input  logic [1:0] turbo_mask,
  input  logic       kp_latch,
  input  logic       kp_clk,
  input  logic       kp_rw,
  input  logic       kp_dout,
  output logic       kp_din,
  output logic [7:0] wr_data,
  output logic       wr_stb
);

  localparam int TCW = $clog2(TURBO_RATE) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  logic [3:0]     sync_reg [SYNC_STAGES];
  logic           latch_s, clk_s, rw_s, dout_s;
  logic           latch_prev_reg, clk_prev_reg;
  logic           latch_rise, clk_rise;
  state_t         state_reg;
  kp_frame_t      sr_reg;
  kp_frame_t      sr_shift_next;
  kp_frame_t      frame_next;
  logic [TCW-1:0] tcnt_reg;
  logic           phase_reg, phase_next;
  logic [1:0]     turbo_kill;
  logic [7:0]     rx_reg, rx_next;
  logic [2:0]     cnt_reg;
  logic [7:0]     wr_data_reg;
  logic           wr_stb_reg;

  assign {dout_s, rw_s, clk_s, latch_s} = sync_reg[SYNC_STAGES-1];

  // Latch has priority: a clock edge coincident with a latch edge is dropped.
  assign latch_rise = latch_s & ~latch_prev_reg;
  assign clk_rise   = clk_s & ~clk_prev_reg & ~latch_rise;

  // The phase used for the load must already reflect this latch edge.
  always_comb begin
    phase_next = phase_reg;
    if (latch_rise && (tcnt_reg == TCW'(TURBO_RATE))) begin
      phase_next = ~phase_reg;
    end
  end

  assign turbo_kill    = phase_next ? turbo_mask : 2'b00;
  assign frame_next    = joypad_to_kp(jp, en, turbo_kill, FRAME_BITS);
  assign sr_shift_next = {1'b0, sr_reg[KP_FRAME_MAX-1:1]};
  assign rx_next       = {dout_s, rx_reg[7:1]};

  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
    end else begin
      sync_reg[0] <= {kp_dout, kp_rw, kp_clk, kp_latch};
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_reg      <= ST_IDLE;
      latch_prev_reg <= 1'b0;
      clk_prev_reg   <= 1'b0;
      sr_reg         <= '0;
      tcnt_reg       <= '0;
      phase_reg      <= 1'b0;
      rx_reg         <= '0;
      cnt_reg        <= '0;
      wr_data_reg    <= '0;
      wr_stb_reg     <= 1'b0;
    end else begin
      latch_prev_reg <= latch_s;
      clk_prev_reg   <= clk_s;
      wr_stb_reg     <= 1'b0;

      if (latch_rise) begin
        phase_reg <= phase_next;
        if (tcnt_reg == TCW'(TURBO_RATE)) begin
          tcnt_reg <= TCW'(1);
        end else begin
          tcnt_reg <= tcnt_reg + 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (latch_rise) begin
            state_reg <= ST_LOAD;
            sr_reg    <= frame_next;
          end
        end
        ST_LOAD: begin
          if (latch_s) begin
            sr_reg <= frame_next;
          end else begin
            state_reg <= ST_SHIFT;
            if (clk_rise) begin
              sr_reg <= sr_shift_next;
            end
          end
        end
        ST_SHIFT: begin
          if (latch_rise) begin
            state_reg <= ST_LOAD;
            sr_reg    <= frame_next;
          end else if (clk_rise) begin
            sr_reg <= sr_shift_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (latch_s) begin
        cnt_reg <= '0;
      end else if (clk_rise && rw_s) begin
        rx_reg  <= rx_next;
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == 3'd7) begin
          wr_data_reg <= rx_next;
          wr_stb_reg  <= 1'b1;
        end
      end
    end
  end

  assign kp_din  = ~sr_reg[0];
  assign wr_data = wr_data_reg;
  assign wr_stb  = wr_stb_reg;

endmodule

// File: rtl/hmi_kport_dev.sv
// K-Port device emulator top: one independent channel per console port.
module hmi_kport_dev
  import hmi_kport_dev_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_RATE  = 2
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  joypad_t [NPORTS-1:0]  JP,
  input  logic [NPORTS-1:0]     PORT_EN,
  input  logic [2*NPORTS-1:0]   TURBO_MASK,
  hmi_kport_dev_if.slave        kp,
  output logic [8*NPORTS-1:0]   WR_DATA,
  output logic [NPORTS-1:0]     WR_STB
);

  logic [NPORTS-1:0] din;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_chan
      hmi_kport_chan #(
        .FRAME_BITS (FRAME_BITS),
        .SYNC_STAGES(SYNC_STAGES),
        .TURBO_RATE (TURBO_RATE)
      ) u_chan (
        .CLK       (CLK),
        .RES       (RES),
        .jp        (JP[gi]),
        .en        (PORT_EN[gi]),
        .turbo_mask(TURBO_MASK[2*gi +: 2]),
        .kp_latch  (kp.KP_LATCH[gi]),
        .kp_clk    (kp.KP_CLK[gi]),
        .kp_rw     (kp.KP_RW[gi]),
        .kp_dout   (kp.KP_DOUT[gi]),
        .kp_din    (din[gi]),
        .wr_data   (WR_DATA[8*gi +: 8]),
        .wr_stb    (WR_STB[gi])
      );
    end
  endgenerate

  assign kp.KP_DIN = din;

endmodule
